// File: rtl/hci_parity_fault_collector.sv
// Collects parity fault pulses into sticky flags, a first-fault index, a saturating counter and an acknowledged alarm.
// Optional HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN adds a free-running cycle counter and first_ts_o.
module hci_parity_fault_collector #(
    parameter int unsigned NumSources = 4,
    parameter int unsigned CntWidth   = 8,
    parameter int unsigned Threshold  = 1,
    parameter int unsigned IdxWidth   = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumSources-1:0] fault_i,
    input  logic [NumSources-1:0] mask_i,
    input  logic                  alarm_ack_i,
    input  logic                  clear_req_i,
    output logic                  clear_gnt_o,
    output logic [NumSources-1:0] fault_sticky_o,
    output logic                  first_valid_o,
    output logic [IdxWidth-1:0]   first_idx_o,
    output logic [CntWidth-1:0]   total_cnt_o,
    output logic                  overflow_o,
    output logic                  alarm_o,
    output logic [1:0]            dbg_state_o
`ifdef HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN
    ,
    output logic [31:0]           first_ts_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        ACKED = 2'd2
    } state_e;

    // Six extra bits hold the popcount of up to 32 sources without wrapping.
    localparam int unsigned SumWidth = CntWidth + 6;
    localparam logic [SumWidth-1:0] CntMax   = {6'd0, {CntWidth{1'b1}}};
    localparam logic [CntWidth-1:0] ThreshVal = CntWidth'(Threshold);

    state_e                  state_q, state_d;
    logic [NumSources-1:0]   ef, sticky_d;
    logic [5:0]              pop;
    logic [IdxWidth-1:0]     low_idx, idx_d;
    logic                    valid_d, ovf_d, grant_d, armed_q, armed_d;
    logic [SumWidth-1:0]     sum;
    logic [CntWidth-1:0]     cnt_d;
    logic [NumSources-1:0]   base_sticky;
    logic                    base_valid, base_ovf;
    logic [IdxWidth-1:0]     base_idx;
    logic [CntWidth-1:0]     base_cnt;
    state_e                  base_state;

    assign ef = fault_i & mask_i;

    // A request is granted once per rising request; armed re-enables after a low cycle.
    always_comb begin
        grant_d = clear_req_i & armed_q & ~clear_gnt_o;
        armed_d = armed_q;
        if (!clear_req_i) begin
            armed_d = 1'b1;
        end else if (grant_d) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        pop     = '0;
        low_idx = '0;
        for (int i = int'(NumSources) - 1; i >= 0; i--) begin
            pop = pop + 6'(ef[i]);
            if (ef[i]) low_idx = IdxWidth'(i);
        end
    end

    // The grant clears state at the same edge, with this cycle's faults applied on top.
    always_comb begin
        base_sticky = grant_d ? '0 : fault_sticky_o;
        base_valid  = grant_d ? 1'b0 : first_valid_o;
        base_idx    = grant_d ? '0 : first_idx_o;
        base_cnt    = grant_d ? '0 : total_cnt_o;
        base_ovf    = grant_d ? 1'b0 : overflow_o;
        base_state  = grant_d ? IDLE : state_q;

        sticky_d = base_sticky | ef;
        valid_d  = base_valid;
        idx_d    = base_idx;
        if (!base_valid && (ef != '0)) begin
            valid_d = 1'b1;
            idx_d   = low_idx;
        end

        sum   = SumWidth'(base_cnt) + SumWidth'(pop);
        cnt_d = sum[CntWidth-1:0];
        ovf_d = base_ovf;
        if (sum > CntMax) begin
            cnt_d = '1;
            ovf_d = 1'b1;
        end

        state_d = base_state;
        case (base_state)
            IDLE:    if (cnt_d >= ThreshVal) state_d = ALARM;
            ALARM:   if (alarm_ack_i && (ef == '0)) state_d = ACKED;
            ACKED:   if (ef != '0) state_d = ALARM;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            clear_gnt_o    <= 1'b0;
            armed_q        <= 1'b1;
            fault_sticky_o <= '0;
            first_valid_o  <= 1'b0;
            first_idx_o    <= '0;
            total_cnt_o    <= '0;
            overflow_o     <= 1'b0;
        end else begin
            state_q        <= state_d;
            clear_gnt_o    <= grant_d;
            armed_q        <= armed_d;
            fault_sticky_o <= sticky_d;
            first_valid_o  <= valid_d;
            first_idx_o    <= idx_d;
            total_cnt_o    <= cnt_d;
            overflow_o     <= ovf_d;
        end
    end

    assign alarm_o     = (state_q == ALARM);
    assign dbg_state_o = state_q;

`ifdef HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ts_q       <= '0;
            first_ts_o <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (!base_valid && (ef != '0)) begin
                first_ts_o <= ts_q;
            end else if (grant_d) begin
                first_ts_o <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hci_parity_fault_collector.sv
// Directed bench for hci_parity_fault_collector: default, Threshold=3 and CntWidth=4 instances share stimulus.
module tb_hci_parity_fault_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fault, mask;
    logic       ack, clear_req;

    int n_checks = 0;
    int n_errors = 0;

    // default instance
    logic       gnt_a, valid_a, ovf_a, alarm_a;
    logic [3:0] sticky_a;
    logic [1:0] idx_a, state_a;
    logic [7:0] cnt_a;
    // Threshold = 3 instance
    logic       gnt_b, valid_b, ovf_b, alarm_b;
    logic [3:0] sticky_b;
    logic [1:0] idx_b, state_b;
    logic [7:0] cnt_b;
    // CntWidth = 4 instance
    logic       gnt_c, valid_c, ovf_c, alarm_c;
    logic [3:0] sticky_c;
    logic [1:0] idx_c, state_c;
    logic [3:0] cnt_c;
`ifdef HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN
    logic [31:0] ts_a, ts_b, ts_c;
`endif

    always #5 clk = ~clk;

    hci_parity_fault_collector #(.NumSources(4), .CntWidth(8), .Threshold(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .mask_i(mask),
        .alarm_ack_i(ack), .clear_req_i(clear_req), .clear_gnt_o(gnt_a),
        .fault_sticky_o(sticky_a), .first_valid_o(valid_a), .first_idx_o(idx_a),
        .total_cnt_o(cnt_a), .overflow_o(ovf_a), .alarm_o(alarm_a), .dbg_state_o(state_a)
`ifdef HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN
        , .first_ts_o(ts_a)
`endif
    );

    hci_parity_fault_collector #(.NumSources(4), .CntWidth(8), .Threshold(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .mask_i(mask),
        .alarm_ack_i(ack), .clear_req_i(clear_req), .clear_gnt_o(gnt_b),
        .fault_sticky_o(sticky_b), .first_valid_o(valid_b), .first_idx_o(idx_b),
        .total_cnt_o(cnt_b), .overflow_o(ovf_b), .alarm_o(alarm_b), .dbg_state_o(state_b)
`ifdef HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN
        , .first_ts_o(ts_b)
`endif
    );

    hci_parity_fault_collector #(.NumSources(4), .CntWidth(4), .Threshold(1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .mask_i(mask),
        .alarm_ack_i(ack), .clear_req_i(clear_req), .clear_gnt_o(gnt_c),
        .fault_sticky_o(sticky_c), .first_valid_o(valid_c), .first_idx_o(idx_c),
        .total_cnt_o(cnt_c), .overflow_o(ovf_c), .alarm_o(alarm_c), .dbg_state_o(state_c)
`ifdef HCI_PARITY_FAULT_COLLECTOR_TIMESTAMP_EN
        , .first_ts_o(ts_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs set beforehand apply to this edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] s, input logic v, input logic [1:0] i,
                           input logic [7:0] c, input logic al);
        check({tag, ".sticky"}, 32'(sticky_a), 32'(s));
        check({tag, ".valid"},  32'(valid_a),  32'(v));
        check({tag, ".idx"},    32'(idx_a),    32'(i));
        check({tag, ".cnt"},    32'(cnt_a),    32'(c));
        check({tag, ".alarm"},  32'(alarm_a),  32'(al));
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        step();
        check("clear.gnt_hi", 32'({gnt_a, gnt_b, gnt_c}), 32'h7);
        clear_req = 1'b0;
        step();
        check("clear.gnt_lo", 32'({gnt_a, gnt_b, gnt_c}), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; fault = 4'hF; mask = 4'hF; ack = 1'b0; clear_req = 1'b0;

        // reset with faults driven
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst.a", 32'({gnt_a, sticky_a, valid_a, idx_a, cnt_a, ovf_a, alarm_a}), 32'h0);
            check("rst.b", 32'({gnt_b, sticky_b, valid_b, idx_b, cnt_b, ovf_b, alarm_b}), 32'h0);
            check("rst.c", 32'({gnt_c, sticky_c, valid_c, idx_c, cnt_c, ovf_c, alarm_c}), 32'h0);
        end
        rst_n = 1'b1; fault = 4'h0;
        step();
        check("post_rst.a", 32'({gnt_a, sticky_a, valid_a, idx_a, cnt_a, ovf_a, alarm_a}), 32'h0);

        // single fault, threshold 1
        fault = 4'b0100;
        step();
        check_a("single", 4'b0100, 1'b1, 2'd2, 8'd1, 1'b1);
        fault = 4'b0000;
        do_clear();
        check_a("cleared", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);

        // masking and first-index freeze
        mask = 4'b0111; fault = 4'b1010;
        step();
        check_a("mask1", 4'b0010, 1'b1, 2'd1, 8'd1, 1'b1);
        fault = 4'b0001;
        step();
        check_a("mask2", 4'b0011, 1'b1, 2'd1, 8'd2, 1'b1);
        mask = 4'hF; fault = 4'b1111;
        step();
        check_a("multi", 4'b1111, 1'b1, 2'd1, 8'd6, 1'b1);

        // acknowledge paths on the default instance
        fault = 4'b0000; ack = 1'b1;
        step();
        check("ack.alarm", 32'(alarm_a), 32'd0);
        check("ack.state", 32'(state_a), 32'd2);
        step();
        check("ack_in_acked", 32'(alarm_a), 32'd0);
        fault = 4'b0001;
        step();
        check("refault.alarm", 32'(alarm_a), 32'd1);
        check("refault.cnt", 32'(cnt_a), 32'd7);
        step();
        check("ack_vs_fault", 32'(alarm_a), 32'd1);
        check("ack_vs_fault.cnt", 32'(cnt_a), 32'd8);
        ack = 1'b0; fault = 4'b0000;
        do_clear();

        // threshold 3: faults in cycles 0, 2, 4
        for (int k = 0; k < 5; k++) begin
            fault = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            step();
            check($sformatf("thr3.c%0d", k), 32'(alarm_b), (k == 4) ? 32'd1 : 32'd0);
        end
        fault = 4'b0000; ack = 1'b1;
        step();
        check("thr3.ack", 32'(alarm_b), 32'd0);
        ack = 1'b0; fault = 4'b0010;
        step();
        check("thr3.refault", 32'(alarm_b), 32'd1);
        ack = 1'b1;
        step();
        check("thr3.ack_vs_fault", 32'(alarm_b), 32'd1);
        check("thr3.cnt", 32'(cnt_b), 32'd5);
        ack = 1'b0; fault = 4'b0000;
        do_clear();

        // CntWidth 4 saturation
        fault = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 15) begin
                check("sat15.cnt", 32'(cnt_c), 32'd15);
                check("sat15.ovf", 32'(ovf_c), 32'd0);
            end
            if (k == 16) check("sat16.ovf", 32'(ovf_c), 32'd1);
        end
        check("sat20.cnt", 32'(cnt_c), 32'd15);
        check("sat20.ovf", 32'(ovf_c), 32'd1);
        fault = 4'b0000;
        do_clear();
        check("satclr", 32'({cnt_c, ovf_c, alarm_c}), 32'h0);

        // clear with a fault in the grant cycle; held request gives one grant
        fault = 4'b0110;
        step();
        check("pre.cnt", 32'(cnt_a), 32'd2);
        clear_req = 1'b1; fault = 4'b0001;
        step();
        check("gc.gnt", 32'(gnt_a), 32'd1);
        check_a("gc", 4'b0001, 1'b1, 2'd0, 8'd1, 1'b1);
        fault = 4'b0000;
        step();
        check("hold1.gnt", 32'(gnt_a), 32'd0);
        check("hold1.cnt", 32'(cnt_a), 32'd1);
        step();
        check("hold2.gnt", 32'(gnt_a), 32'd0);
        clear_req = 1'b0;
        step();
        check("drop.gnt", 32'(gnt_a), 32'd0);
        clear_req = 1'b1;
        step();
        check("regrant.gnt", 32'(gnt_a), 32'd1);
        check_a("regrant", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
        clear_req = 1'b0;
        step();

        // fully masked faults are ignored; mask selects only bit 3
        mask = 4'b0000; fault = 4'b1111;
        step();
        check_a("allmask", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
        mask = 4'b1000; fault = 4'b1001;
        step();
        check_a("mask3", 4'b1000, 1'b1, 2'd3, 8'd1, 1'b1);

        // reset during a clear handshake
        fault = 4'b0000; clear_req = 1'b1; rst_n = 1'b0;
        step();
        check("rst_hs.a", 32'({gnt_a, sticky_a, valid_a, idx_a, cnt_a, ovf_a, alarm_a}), 32'h0);
        clear_req = 1'b0; rst_n = 1'b1;
        step();
        check("rst_hs.after", 32'(gnt_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
